expu_acc: RTL and testbench
===========================

# expu_acc

Streaming bfloat16 accumulator that sits directly downstream of `expu_top`. It sums the non-negative exponentials produced by `expu_top` over a group of beats delimited by `last_i`, which forms the softmax denominator. It presents the rounded sum with a valid/ready output handshake. Addition is restricted to non-negative operands, so normalisation only ever shifts right and no leading-zero count is needed.

## Interface
- `EXPONENT_BITS`, 8: exponent width of input and output floats.
- `MANTISSA_BITS`, 7: stored mantissa width of input and output floats.
- `GUARD_BITS`, 8: extra internal mantissa LSBs kept below the output precision.
- `COUNT_WIDTH`, 16: width of the beat counter.

Ports:
- `clk_i` in 1: clock.
- `rst_ni` in 1: asynchronous active-low reset.
- `clear_i` in 1: synchronous clear; returns the block to IDLE and zeroes all state.
- `enable_i` in 1: gates input acceptance only.
- `valid_i` in 1: input beat valid.
- `ready_o` out 1: input beat accepted when `valid_i & ready_o`.
- `float_i` in 1+E+M: `{sign, exp, mant}` from `expu_top.float_o`.
- `last_i` in 1: marks the final beat of a group.
- `valid_o` out 1: sum available.
- `ready_i` in 1: downstream accepts the sum.
- `sum_o` out 1+E+M: rounded group sum; sign bit is always 0.
- `count_o` out COUNT_WIDTH: beats accepted in the current group, saturating.
- `neg_o` out 1: sticky flag; a beat with sign=1 was accepted in this group.

## Operation
- States:
  - IDLE: accumulator = 0.
  - ACCUM.
  - DONE.
- `ready_o = enable_i & (state != DONE)`.
- State transitions:
  - IDLE → ACCUM on an accepted beat without `last_i`.
  - IDLE/ACCUM → DONE on an accepted beat with `last_i`.
  - DONE → IDLE when `valid_o & ready_i`; the accumulator, `count_o` and `neg_o` are zeroed on this transition.
- `clear_i` has priority over every other event, including a same-cycle handshake.
- `enable_i = 0` does not block the output handshake in DONE.
- Operand classification:
  - sign=1 → operand treated as 0; set `neg_o`.
  - exp=0 (zero/subnormal) → operand is 0 (flush).
  - exp=all-ones, mant≠0 → sticky NaN.
  - exp=all-ones, mant=0 → sticky Inf.
- Internal accumulator: exponent `EA` (E bits), significand `SA` of 1+M+GUARD_BITS bits including an explicit hidden bit, plus NaN and Inf sticky bits.
- Add, combinational, registered each accepted beat:
  - The larger-exponent operand is the reference.
  - The smaller significand is shifted right by the exponent difference; bits below the guard LSB are truncated.
  - A shift ≥ 1+M+GUARD_BITS contributes 0.
  - If the add carries out: shift right by 1 (truncating) and increment the exponent.
  - If the exponent reaches all-ones: set Inf.
- Output `sum_o`, combinational from the accumulator registers, stable while `valid_o = 1`:
  - NaN → `{0, all-ones, 1, 0…}` (0x7FC0 for defaults). NaN has priority over Inf.
  - Inf → 0x7F80.
  - Accumulator empty/zero → 0x0000.
  - Otherwise: round-to-nearest-even from GUARD_BITS down to M bits. A rounding carry increments the exponent; if that reaches all-ones the output is Inf.
- `count_o` increments on every accepted beat (zero operands included) and saturates at 2^COUNT_WIDTH−1.

## Timing
- Reset values:
  - state IDLE.
  - `valid_o` = 0.
  - `ready_o` = 0 while `enable_i` = 0.
  - `sum_o` = 0.
  - `count_o` = 0.
  - `neg_o` = 0.
- Throughput: one beat per cycle. Accumulation latency is 1 cycle: the accumulator is updated at the clock edge where the beat is accepted.
- `valid_o` rises the cycle after the `last_i` beat is accepted. `sum_o` is already final in that cycle.
- Held sum: `valid_o` and `sum_o` stay constant until `ready_i`.
- Back-to-back groups: `ready_o` returns in the cycle after the output handshake. There is one bubble per group.
- A single-beat group with `last_i` asserted in IDLE is legal: DONE is reached in the next cycle with `count_o = 1`.
- Reset asserted mid-group: all state is lost immediately and asynchronously; no partial sum is emitted.

## Test plan
- Three beats of 0x3F80 (1.0), the last with `last_i` → `valid_o` one cycle later, `sum_o` = 0x4040, `count_o` = 3.
- 0x4380 (256.0), 0x3F80, 0x3F80 (last) → `sum_o` = 0x4381 (258). Same group with only one 0x3F80 → 0x4380 (tie rounds to even).
- 0x7F7F + 0x7F7F (last) → 0x7F80. Group of 0x3F80, 0x7FC1, 0x7F80 (last) → 0x7FC0.
- 0xBF80, then 0x3F80 (last) → `sum_o` = 0x3F80, `neg_o` = 1, `count_o` = 2. 0x0001 (subnormal) alone → 0x0000.
- Hold `ready_i` low 3 cycles in DONE while `valid_i` = 1 → `ready_o` stays 0 and `sum_o` is held. Raise `ready_i` → the next group starts one cycle later with count 0.
- `clear_i` in the middle of ACCUM, and `rst_ni` pulsed in DONE → IDLE, `valid_o` = 0. A following single 0x4000 (last) beat yields 0x4000.

Source files
------------

// File: rtl/expu_acc.sv
// expu_acc: streaming bfloat16 accumulator for the softmax denominator.
// It sums the non-negative exponentials from expu_top over one group of beats.
// A group ends with the beat that has last_i set. The rounded sum is then
// presented on a valid/ready output handshake.
//
// Ports:
//   clk_i, rst_ni       clock, asynchronous active-low reset
//   clear_i             synchronous clear back to IDLE, all state zeroed
//   enable_i            gates input acceptance only
//   valid_i / ready_o   input beat handshake
//   float_i, last_i     input float {sign, exp, mant} and end-of-group marker
//   valid_o / ready_i   output sum handshake
//   sum_o               rounded group sum (sign always 0)
//   count_o             beats accepted in the current group (saturating)
//   neg_o               a negative beat was accepted in this group
//
// state | meaning
// IDLE  | accumulator empty, waiting for the first beat of a group
// ACCUM | group in progress
// DONE  | group closed, sum presented on valid_o until ready_i
module expu_acc #(
    parameter int EXPONENT_BITS = 8,
    parameter int MANTISSA_BITS = 7,
    parameter int GUARD_BITS    = 8,
    parameter int COUNT_WIDTH   = 16
) (
    input  logic                                   clk_i,
    input  logic                                   rst_ni,
    input  logic                                   clear_i,
    input  logic                                   enable_i,
    input  logic                                   valid_i,
    output logic                                   ready_o,
    input  logic [EXPONENT_BITS+MANTISSA_BITS:0]   float_i,
    input  logic                                   last_i,
    output logic                                   valid_o,
    input  logic                                   ready_i,
    output logic [EXPONENT_BITS+MANTISSA_BITS:0]   sum_o,
    output logic [COUNT_WIDTH-1:0]                 count_o,
    output logic                                   neg_o
);

    localparam int E  = EXPONENT_BITS;
    localparam int M  = MANTISSA_BITS;
    localparam int G  = GUARD_BITS;
    localparam int SW = 1 + M + G;
    localparam logic [E-1:0] EXP_MAX = {E{1'b1}};

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t state, state_nxt;

    logic [E-1:0]  acc_exp;
    logic [SW-1:0] acc_sig;
    logic          acc_nan, acc_inf;

    logic          accept, handshake;
    logic          in_sign;
    logic [E-1:0]  in_exp;
    logic [M-1:0]  in_mant;
    logic          op_nan, op_inf, op_num;
    logic [SW-1:0] op_sig;

    assign accept    = valid_i & ready_o;
    assign handshake = valid_o & ready_i;

    // Operand classification. A negative operand is dropped whatever its
    // encoding, so a negative NaN or Inf never poisons the sum.
    assign in_sign = float_i[E+M];
    assign in_exp  = float_i[E+M-1:M];
    assign in_mant = float_i[M-1:0];
    assign op_nan  = !in_sign && (in_exp == EXP_MAX) && (in_mant != '0);
    assign op_inf  = !in_sign && (in_exp == EXP_MAX) && (in_mant == '0);
    assign op_num  = !in_sign && (in_exp != '0) && (in_exp != EXP_MAX);
    assign op_sig  = {1'b1, in_mant, {G{1'b0}}};

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state
    always_comb begin
        state_nxt = state;
        if (clear_i) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (accept) state_nxt = last_i ? DONE : ACCUM;
                ACCUM:   if (accept && last_i) state_nxt = DONE;
                DONE:    if (handshake) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Outputs
    always_comb begin
        ready_o = enable_i && (state != DONE);
        valid_o = (state == DONE);
    end

    // Adder. Both operands are non-negative, so the result only ever
    // needs a single right shift on carry-out. An empty accumulator
    // (exp 0) always shifts out completely, which loads the operand as is.
    logic [E-1:0]  add_exp, big_exp, diff;
    logic [SW-1:0] add_sig, big_sig, small_sig, shifted;
    logic [SW:0]   sum_wide;
    logic          add_inf;

    always_comb begin
        add_exp   = acc_exp;
        add_sig   = acc_sig;
        add_inf   = acc_inf;
        big_exp   = acc_exp;
        big_sig   = acc_sig;
        small_sig = op_sig;
        diff      = '0;
        shifted   = '0;
        sum_wide  = '0;
        if (op_num && !acc_inf && !acc_nan) begin
            if (in_exp > acc_exp) begin
                big_exp   = in_exp;
                big_sig   = op_sig;
                small_sig = acc_sig;
                diff      = in_exp - acc_exp;
            end else begin
                diff      = acc_exp - in_exp;
            end
            shifted  = (32'(diff) >= SW) ? '0 : (small_sig >> diff);
            sum_wide = {1'b0, big_sig} + {1'b0, shifted};
            if (sum_wide[SW]) begin
                add_sig = sum_wide[SW:1];
                add_exp = big_exp + 1'b1;
                if (add_exp == EXP_MAX) add_inf = 1'b1;
            end else begin
                add_sig = sum_wide[SW-1:0];
                add_exp = big_exp;
            end
        end
    end

    // Accumulator, beat counter and negative flag
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_exp <= '0;
            acc_sig <= '0;
            acc_nan <= 1'b0;
            acc_inf <= 1'b0;
            count_o <= '0;
            neg_o   <= 1'b0;
        end else if (clear_i || handshake) begin
            acc_exp <= '0;
            acc_sig <= '0;
            acc_nan <= 1'b0;
            acc_inf <= 1'b0;
            count_o <= '0;
            neg_o   <= 1'b0;
        end else if (accept) begin
            acc_exp <= add_exp;
            acc_sig <= add_sig;
            acc_nan <= acc_nan | op_nan;
            acc_inf <= add_inf | op_inf;
            if (count_o != {COUNT_WIDTH{1'b1}}) count_o <= count_o + 1'b1;
            neg_o   <= neg_o | in_sign;
        end
    end

    // Round-to-nearest-even of the stored mantissa from the guard bits.
    // A mantissa carry means the significand rolled over to 2.0.
    logic          rnd_bit, sticky, round_up;
    logic [M:0]    mant_r;
    logic [E-1:0]  out_exp;

    always_comb begin
        rnd_bit  = acc_sig[G-1];
        sticky   = |acc_sig[G-2:0];
        round_up = rnd_bit && (sticky || acc_sig[G]);
        mant_r   = {1'b0, acc_sig[SW-2:G]} + {{M{1'b0}}, round_up};
        out_exp  = mant_r[M] ? acc_exp + 1'b1 : acc_exp;
        if (acc_nan) begin
            sum_o = {1'b0, EXP_MAX, 1'b1, {(M-1){1'b0}}};
        end else if (acc_inf || (out_exp == EXP_MAX)) begin
            sum_o = {1'b0, EXP_MAX, {M{1'b0}}};
        end else if (acc_sig == '0) begin
            sum_o = '0;
        end else begin
            sum_o = {1'b0, out_exp, mant_r[M-1:0]};
        end
    end

endmodule

// File: tb/tb_expu_acc.sv
module tb_expu_acc;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        clear_i;
    logic        enable_i;
    logic        valid_i;
    logic        ready_o;
    logic [15:0] float_i;
    logic        last_i;
    logic        valid_o;
    logic        ready_i;
    logic [15:0] sum_o;
    logic [15:0] count_o;
    logic        neg_o;

    int tests = 0;
    int fails = 0;

    expu_acc dut (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .clear_i  (clear_i),
        .enable_i (enable_i),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .float_i  (float_i),
        .last_i   (last_i),
        .valid_o  (valid_o),
        .ready_i  (ready_i),
        .sum_o    (sum_o),
        .count_o  (count_o),
        .neg_o    (neg_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Present one beat; returns 1 time unit after the edge that accepts it.
    task automatic send(input logic [15:0] v, input logic l);
        valid_i = 1'b1;
        float_i = v;
        last_i  = l;
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        last_i  = 1'b0;
    endtask

    // Complete the output handshake for one cycle.
    task automatic take();
        ready_i = 1'b1;
        @(posedge clk_i); #1;
        ready_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0; clear_i = 1'b0; enable_i = 1'b0; valid_i = 1'b0;
        float_i = '0; last_i = 1'b0; ready_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        tests++; if (ready_o !== 1'b0) begin fails++; $display("FAIL reset_ready got %b want 0", ready_o); end
        tests++; if (valid_o !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", valid_o); end
        tests++; if (sum_o !== 16'h0000) begin fails++; $display("FAIL reset_sum got %h want 0000", sum_o); end
        tests++; if (count_o !== 16'd0) begin fails++; $display("FAIL reset_count got %0d want 0", count_o); end
        tests++; if (neg_o !== 1'b0) begin fails++; $display("FAIL reset_neg got %b want 0", neg_o); end
        rst_ni = 1'b1;
        @(posedge clk_i); #1;
        enable_i = 1'b1;
        #1;
        tests++; if (ready_o !== 1'b1) begin fails++; $display("FAIL enabled_ready got %b want 1", ready_o); end
    endtask

    task automatic test_three_ones();
        send(16'h3F80, 1'b0);
        send(16'h3F80, 1'b0);
        tests++; if (valid_o !== 1'b0) begin fails++; $display("FAIL ones_valid_early got %b want 0", valid_o); end
        send(16'h3F80, 1'b1);
        tests++; if (valid_o !== 1'b1) begin fails++; $display("FAIL ones_valid got %b want 1", valid_o); end
        tests++; if (sum_o !== 16'h4040) begin fails++; $display("FAIL ones_sum got %h want 4040", sum_o); end
        tests++; if (count_o !== 16'd3) begin fails++; $display("FAIL ones_count got %0d want 3", count_o); end
        take();
        tests++; if (valid_o !== 1'b0) begin fails++; $display("FAIL ones_valid_after got %b want 0", valid_o); end
        tests++; if (count_o !== 16'd0) begin fails++; $display("FAIL ones_count_after got %0d want 0", count_o); end
    endtask

    task automatic test_rounding();
        send(16'h4380, 1'b0);
        send(16'h3F80, 1'b0);
        send(16'h3F80, 1'b1);
        tests++; if (sum_o !== 16'h4381) begin fails++; $display("FAIL round_258 got %h want 4381", sum_o); end
        take();
        send(16'h4380, 1'b0);
        send(16'h3F80, 1'b1);
        tests++; if (sum_o !== 16'h4380) begin fails++; $display("FAIL round_tie_even got %h want 4380", sum_o); end
        take();
    endtask

    task automatic test_special();
        send(16'h7F7F, 1'b0);
        send(16'h7F7F, 1'b1);
        tests++; if (sum_o !== 16'h7F80) begin fails++; $display("FAIL overflow_inf got %h want 7f80", sum_o); end
        take();
        send(16'h3F80, 1'b0);
        send(16'h7FC1, 1'b0);
        send(16'h7F80, 1'b1);
        tests++; if (sum_o !== 16'h7FC0) begin fails++; $display("FAIL nan_priority got %h want 7fc0", sum_o); end
        take();
    endtask

    task automatic test_neg_flush();
        send(16'hBF80, 1'b0);
        send(16'h3F80, 1'b1);
        tests++; if (sum_o !== 16'h3F80) begin fails++; $display("FAIL neg_sum got %h want 3f80", sum_o); end
        tests++; if (neg_o !== 1'b1) begin fails++; $display("FAIL neg_flag got %b want 1", neg_o); end
        tests++; if (count_o !== 16'd2) begin fails++; $display("FAIL neg_count got %0d want 2", count_o); end
        take();
        tests++; if (neg_o !== 1'b0) begin fails++; $display("FAIL neg_cleared got %b want 0", neg_o); end
        send(16'h0001, 1'b1);
        tests++; if (sum_o !== 16'h0000) begin fails++; $display("FAIL subnormal_sum got %h want 0000", sum_o); end
        tests++; if (count_o !== 16'd1) begin fails++; $display("FAIL single_count got %0d want 1", count_o); end
        take();
    endtask

    task automatic test_back_to_back();
        send(16'h3F80, 1'b1);
        valid_i = 1'b1;
        float_i = 16'h4000;
        last_i  = 1'b0;
        ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_i); #1;
            tests++; if (ready_o !== 1'b0) begin fails++; $display("FAIL hold_ready cycle %0d got %b want 0", i, ready_o); end
            tests++; if (valid_o !== 1'b1 || sum_o !== 16'h3F80) begin
                fails++; $display("FAIL hold_sum cycle %0d got valid %b sum %h want 1 3f80", i, valid_o, sum_o);
            end
        end
        ready_i = 1'b1;
        @(posedge clk_i); #1;
        ready_i = 1'b0;
        tests++; if (ready_o !== 1'b1 || count_o !== 16'd0) begin
            fails++; $display("FAIL b2b_restart got ready %b count %0d want 1 0", ready_o, count_o);
        end
        @(posedge clk_i); #1;
        tests++; if (count_o !== 16'd1) begin fails++; $display("FAIL b2b_first_beat got %0d want 1", count_o); end
        send(16'h3F80, 1'b1);
        tests++; if (sum_o !== 16'h4040 || count_o !== 16'd2) begin
            fails++; $display("FAIL b2b_sum got %h count %0d want 4040 2", sum_o, count_o);
        end
        take();
    endtask

    task automatic test_clear_reset();
        send(16'h4000, 1'b0);
        send(16'h4000, 1'b0);
        clear_i = 1'b1;
        @(posedge clk_i); #1;
        clear_i = 1'b0;
        tests++; if (valid_o !== 1'b0 || count_o !== 16'd0 || sum_o !== 16'h0000) begin
            fails++; $display("FAIL clear_state got valid %b count %0d sum %h want 0 0 0000", valid_o, count_o, sum_o);
        end
        send(16'h4000, 1'b1);
        tests++; if (sum_o !== 16'h4000 || count_o !== 16'd1) begin
            fails++; $display("FAIL after_clear got %h count %0d want 4000 1", sum_o, count_o);
        end
        rst_ni = 1'b0;
        #2;
        tests++; if (valid_o !== 1'b0 || sum_o !== 16'h0000) begin
            fails++; $display("FAIL async_reset got valid %b sum %h want 0 0000", valid_o, sum_o);
        end
        rst_ni = 1'b1;
        send(16'h4000, 1'b1);
        tests++; if (valid_o !== 1'b1 || sum_o !== 16'h4000) begin
            fails++; $display("FAIL after_reset got valid %b sum %h want 1 4000", valid_o, sum_o);
        end
        enable_i = 1'b0;
        take();
        tests++; if (valid_o !== 1'b0) begin fails++; $display("FAIL disabled_handshake got %b want 0", valid_o); end
        enable_i = 1'b1;
    endtask

    initial begin
        test_reset();
        test_three_ones();
        test_rounding();
        test_special();
        test_neg_flush();
        test_back_to_back();
        test_clear_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
